// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer register map, TCR bit positions and APB FSM encoding
package timer_pkg;

  // Register map
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  // TCR bit positions
  localparam int TCR_LOAD        = 7;
  localparam int TCR_DW          = 5;
  localparam int TCR_EN          = 4;
  localparam int TCR_CLK_SEL_MSB = 1;
  localparam int TCR_CLK_SEL_LSB = 0;

  // Software-writable TCR bits; every other bit is hard-wired to zero
  localparam logic [7:0] TCR_WR_MASK = (8'd1 << TCR_LOAD) | (8'd1 << TCR_DW) | (8'd1 << TCR_EN) |
                                       (8'd1 << TCR_CLK_SEL_MSB) | (8'd1 << TCR_CLK_SEL_LSB);

  // TSR sticky flag positions
  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // APB slave phase tracking
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/timer_sts_flag.sv
// rtl/timer_sts_flag.sv - one sticky status flag, hardware set wins over software clear
module timer_sts_flag (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Set has priority so a coincident clear never loses an event
  always_comb begin
    flag_d = flag_q;
    if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end
  end

  // Flag storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/timer_apb_regif.sv
// rtl/timer_apb_regif.sv - APB register interface for the timer (TDR/TCR/TSR/TCNT)
module timer_apb_regif
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr,
  output logic [7:0]        tcr,
  output logic              load_pulse,
  input  logic [7:0]        tcnt,
  input  logic              ovf_set,
  input  logic              udf_set,
  output logic              irq
);

  // Number of ACCESS cycles already spent when the transfer may complete
  localparam logic [1:0] WCNT_LAST = 2'(WAIT_STATES);

  apb_state_e state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] tdr_q;
  logic [7:0] tcr_q;
  logic       load_pulse_q;
  logic       ovf_flag, udf_flag;
  logic       sel_tdr, sel_tcr, sel_tsr, sel_tcnt;
  logic       access_err;
  logic       wr_commit;
  logic [7:0] rd_mux;

  assign sel_tdr    = (paddr == ADDR_W'(ADDR_TDR));
  assign sel_tcr    = (paddr == ADDR_W'(ADDR_TCR));
  assign sel_tsr    = (paddr == ADDR_W'(ADDR_TSR));
  assign sel_tcnt   = (paddr == ADDR_W'(ADDR_TCNT));
  assign access_err = !(sel_tdr || sel_tcr || sel_tsr || sel_tcnt) || (pwrite && sel_tcnt);

  // FSM state register and wait-cycle counter
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FSM next state: SETUP is held during the first ACCESS bus cycle, ACCESS covers the waits
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: begin
        wcnt_d = 2'd0;
        if (psel && !penable) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!psel) begin
          state_d = ST_IDLE;
          wcnt_d  = 2'd0;
        end else if (!penable) begin
          state_d = ST_SETUP;
          wcnt_d  = 2'd0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = ST_IDLE;
          wcnt_d  = 2'd0;
        end else begin
          state_d = ST_ACCESS;
          wcnt_d  = wcnt_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 2'd0;
      end
    endcase
  end

  // Read data source for the addressed register
  always_comb begin
    rd_mux = 8'h00;
    if (sel_tdr) begin
      rd_mux = tdr_q;
    end else if (sel_tcr) begin
      rd_mux = tcr_q;
    end else if (sel_tsr) begin
      rd_mux = {6'b0, udf_flag, ovf_flag};
    end else if (sel_tcnt) begin
      rd_mux = tcnt;
    end
  end

  // FSM outputs: completion, error, commit strobe and gated read data
  always_comb begin
    pready    = 1'b0;
    pslverr   = 1'b0;
    wr_commit = 1'b0;
    prdata    = 8'h00;
    if ((state_q != ST_IDLE) && psel && penable && (wcnt_q == WCNT_LAST)) begin
      pready    = 1'b1;
      pslverr   = access_err;
      wr_commit = pwrite && !access_err;
      if (!pwrite && !access_err) begin
        prdata = rd_mux;
      end
    end
  end

  // TDR/TCR storage; TCR load bit clears the cycle after its pulse
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      tdr_q        <= 8'h00;
      tcr_q        <= 8'h00;
      load_pulse_q <= 1'b0;
    end else begin
      load_pulse_q <= wr_commit && sel_tcr && pwdata[TCR_LOAD];
      if (wr_commit && sel_tdr) begin
        tdr_q <= pwdata;
      end
      if (wr_commit && sel_tcr) begin
        tcr_q <= pwdata & TCR_WR_MASK;
      end else if (load_pulse_q) begin
        tcr_q[TCR_LOAD] <= 1'b0;
      end
    end
  end

  timer_sts_flag u_ovf_flag (
    .clk    (pclk),
    .rst    (prst),
    .set_i  (ovf_set),
    .clr_i  (wr_commit && sel_tsr && !pwdata[TSR_OVF]),
    .flag_o (ovf_flag)
  );

  timer_sts_flag u_udf_flag (
    .clk    (pclk),
    .rst    (prst),
    .set_i  (udf_set),
    .clr_i  (wr_commit && sel_tsr && !pwdata[TSR_UDF]),
    .flag_o (udf_flag)
  );

  assign tdr        = tdr_q;
  assign tcr        = tcr_q;
  assign load_pulse = load_pulse_q;
  assign irq        = ovf_flag | udf_flag;

endmodule

// File: doc/timer_apb_regif.md
TIMER_APB_REGIF -- requirements
Module: timer_apb_regif

Interface
REQ-001 SHALL have parameter WAIT_STATES, 1, number of extra ACCESS cycles before pready (0..3).
REQ-002 SHALL have parameter ADDR_W, 8, APB address width.
REQ-003 SHALL have port pclk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port prst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports psel, penable, pwrite  input  1 each  APB control from the initiator.
REQ-006 SHALL have port paddr  input  ADDR_W  register address.
REQ-007 SHALL have ports pwdata  input  8 and prdata  output  8  APB write and read data.
REQ-008 SHALL have ports pready, pslverr  output  1 each  transfer completion and error.
REQ-009 SHALL have port tdr  output  8  load value to the counter core.
REQ-010 SHALL have port tcr  output  8  control: load[7], dw[5], en[4], clk_sel[1:0]; bits 6 and 3:2 SHALL read 0.
REQ-011 SHALL have port load_pulse  output  1  one-cycle pulse when a TCR write sets load=1.
REQ-012 SHALL have port tcnt  input  8  live counter value, read-only.
REQ-013 SHALL have ports ovf_set, udf_set  input  1 each  one-cycle hardware flag-set pulses.
REQ-014 SHALL have port irq  output  1  equal to the OR of TSR[1:0].

Function
REQ-015 SHALL decode addresses TDR=0x00, TCR=0x01, TSR=0x02, TCNT=0x03; all other addresses are invalid.
REQ-016 SHALL implement FSM IDLE -> SETUP (psel & !penable) -> ACCESS (psel & penable), remaining in ACCESS for WAIT_STATES cycles, then asserting pready for exactly one cycle and returning to IDLE (or SETUP if a new psel without penable is present).
REQ-017 SHALL commit a write, and sample prdata, only in the cycle where psel & penable & pready.
REQ-018 SHALL drive prdata to 0x00 whenever pready is low.
REQ-019 SHALL assert pslverr together with pready for an invalid address or a write to TCNT; such a write SHALL modify no register, and such a read SHALL return 0x00.
REQ-020 SHALL make TDR fully read/write.
REQ-021 SHALL make TCR writable only in bits 7,5,4,1:0; bit 7 SHALL self-clear one cycle after load_pulse.
REQ-022 SHALL make TSR bit 0 (ovf) and bit 1 (udf) sticky: each is set by its set pulse and cleared by a committed TSR write carrying 0 in that bit; writing 1 SHALL leave the bit unchanged; bits 7:2 SHALL read 0.
REQ-023 SHALL give a hardware set priority over a software clear in the same cycle (the flag ends the cycle at 1).
REQ-024 SHALL return to IDLE without committing the transfer, and with pready low, if psel deasserts in SETUP or ACCESS.
REQ-025 SHALL make a TCNT read return the tcnt value sampled in the pready cycle.

Reset
REQ-026 SHALL, while prst=1, asynchronously force FSM=IDLE, tdr=0x00, tcr=0x00, TSR=0x00, prdata=0x00, pready=0, pslverr=0, load_pulse=0, irq=0.
REQ-027 SHALL abandon a transfer in progress when reset asserts; no register write commits.

Structure
REQ-028 SHALL take register address constants, TCR bit-position constants and the FSM state encoding from the shared define/package file used by the timer.
REQ-029 SHALL keep the sticky status flags in a sub-module timer_sts_flag, instantiated once per TSR bit.

Verification
REQ-030 SHALL cover: write TCR=0x13, then read TCR -> 0x13, pready after 1+WAIT_STATES ACCESS cycles, pslverr=0.
REQ-031 SHALL cover: write TCR=0xFF -> readback 0xB3 the cycle after, then 0x33; load_pulse high exactly one cycle.
REQ-032 SHALL cover: ovf_set pulse -> TSR=0x01, irq=1; write TSR=0x01 -> TSR stays 0x01; write TSR=0x00 -> TSR=0x00, irq=0.
REQ-033 SHALL cover: ovf_set coincident with a committed write TSR=0x00 -> TSR=0x01.
REQ-034 SHALL cover: write 0x55 to address 0x07 and to TCNT -> pslverr=1, all registers unchanged; read 0x07 -> prdata=0x00.
REQ-035 SHALL cover: prst asserted mid-ACCESS of write TDR=0xAA -> TDR=0x00, FSM IDLE, no pready.
